// File: rtl/pcie_tlp_assembler.sv
`default_nettype none
// ============================================================================
// Module      : pcie_tlp_assembler
// Description : Multi-channel TLP assembler for the tail of the PCIe TX path.
//               Round-robin arbitrates between NUM_CH header FIFOs (with
//               optional per-channel payload FIFOs) and emits a single
//               valid/ready beat stream: one header beat followed by any
//               payload beats, marked with sop/eop. Payloads longer than
//               MAX_PLD_BEATS are truncated (eop forced), the remainder is
//               drained silently and a sticky overrun flag is raised.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               hdr_empty_i/rdata_i - header FIFO heads (first-word fall-through)
//               hdr_rden_o          - header FIFO pop (one-hot or zero)
//               pld_empty_i/rdata_i - payload FIFO heads, MSB of slice = last
//               pld_rden_o          - payload FIFO pop (one-hot or zero)
//               tlp_*               - output beat stream with sop/eop/channel
//               pld_overrun_o       - sticky payload overrun error
//               tlp_cnt_o           - count of completed TLPs (wrapping)
// Revision    : 1.0 - initial release
// ============================================================================
module pcie_tlp_assembler #(
    parameter int                NUM_CH        = 2,
    parameter int                HDR_WIDTH     = 128,
    parameter int                DATA_WIDTH    = 256,
    parameter logic [NUM_CH-1:0] HAS_PLD       = 2'b01,
    parameter int                MAX_PLD_BEATS = 16,
    parameter int                CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_CH-1:0]                hdr_empty_i,
    input  logic [NUM_CH*HDR_WIDTH-1:0]      hdr_rdata_i,
    output logic [NUM_CH-1:0]                hdr_rden_o,
    input  logic [NUM_CH-1:0]                pld_empty_i,
    input  logic [NUM_CH*(DATA_WIDTH+1)-1:0] pld_rdata_i,
    output logic [NUM_CH-1:0]                pld_rden_o,
    output logic                             tlp_valid_o,
    input  logic                             tlp_ready_i,
    output logic [DATA_WIDTH-1:0]            tlp_data_o,
    output logic                             tlp_sop_o,
    output logic                             tlp_eop_o,
    output logic [CH_W-1:0]                  tlp_ch_o,
    output logic                             pld_overrun_o,
    output logic [31:0]                      tlp_cnt_o
);

    localparam int c_CNT_W = $clog2(MAX_PLD_BEATS + 1);
    localparam int c_PW    = DATA_WIDTH + 1;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_PLD   = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;

    logic [1:0]            r_state;
    logic [CH_W-1:0]       r_ptr;
    logic [CH_W-1:0]       r_ch;
    logic [c_CNT_W-1:0]    r_cnt;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_sop;
    logic                  r_eop;
    logic                  r_overrun;
    logic [31:0]           r_tlp_cnt;

    logic [NUM_CH-1:0]     w_elig;
    logic                  w_any;
    logic [CH_W-1:0]       w_gnt_lo;
    logic [CH_W-1:0]       w_gnt_hi;
    logic                  w_hi_found;
    logic [CH_W-1:0]       w_gnt;
    logic [CH_W-1:0]       w_ptr_next;
    logic [HDR_WIDTH-1:0]  w_hdr_sel;
    logic [c_PW-1:0]       w_pld_sel;
    logic                  w_pld_last;
    logic                  w_pld_avail;
    logic                  w_has_pld_gnt;
    logic                  w_load_ok;
    logic [c_CNT_W-1:0]    w_cnt_inc;

    logic [1:0]            w_state_nxt;
    logic [NUM_CH-1:0]     w_hdr_pop;
    logic [NUM_CH-1:0]     w_pld_pop;
    logic                  w_load;
    logic                  w_grant;
    logic [DATA_WIDTH-1:0] w_data_nxt;
    logic                  w_sop_nxt;
    logic                  w_eop_nxt;
    logic [c_CNT_W-1:0]    w_cnt_nxt;
    logic                  w_set_ovr;

    // A channel is eligible only when a whole TLP can start: header present
    // and, for payload-carrying channels, at least the first payload beat.
    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_elig
            assign w_elig[i] = !hdr_empty_i[i] && (!HAS_PLD[i] || !pld_empty_i[i]);
        end
    endgenerate

    assign w_any = |w_elig;

    // Round-robin: lowest eligible index at or above the pointer, else the
    // lowest eligible index overall. Descending scan leaves the lowest hit.
    always_comb begin
        w_gnt_lo   = '0;
        w_gnt_hi   = '0;
        w_hi_found = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_gnt_lo = CH_W'(i);
            end
            if (w_elig[i] && (i >= int'(r_ptr))) begin
                w_gnt_hi   = CH_W'(i);
                w_hi_found = 1'b1;
            end
        end
    end

    assign w_gnt         = w_hi_found ? w_gnt_hi : w_gnt_lo;
    assign w_ptr_next    = (int'(w_gnt) == NUM_CH - 1) ? '0 : w_gnt + CH_W'(1);
    assign w_has_pld_gnt = HAS_PLD[w_gnt];
    assign w_hdr_sel     = hdr_rdata_i[w_gnt*HDR_WIDTH +: HDR_WIDTH];
    assign w_pld_sel     = pld_rdata_i[r_ch*c_PW +: c_PW];
    assign w_pld_last    = w_pld_sel[DATA_WIDTH];
    assign w_pld_avail   = !pld_empty_i[r_ch];
    assign w_load_ok     = !r_valid || tlp_ready_i;
    assign w_cnt_inc     = r_cnt + c_CNT_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_hdr_pop   = '0;
        w_pld_pop   = '0;
        w_load      = 1'b0;
        w_grant     = 1'b0;
        w_data_nxt  = r_data;
        w_sop_nxt   = r_sop;
        w_eop_nxt   = r_eop;
        w_cnt_nxt   = r_cnt;
        w_set_ovr   = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_any && w_load_ok) begin
                    w_grant          = 1'b1;
                    w_hdr_pop[w_gnt] = 1'b1;
                    w_load           = 1'b1;
                    w_data_nxt       = DATA_WIDTH'(w_hdr_sel);
                    w_sop_nxt        = 1'b1;
                    w_eop_nxt        = !w_has_pld_gnt;
                    w_cnt_nxt        = '0;
                    if (w_has_pld_gnt) begin
                        w_state_nxt = c_PLD;
                    end
                end
            end
            c_PLD: begin
                if (w_pld_avail && w_load_ok) begin
                    w_pld_pop[r_ch] = 1'b1;
                    w_load          = 1'b1;
                    w_data_nxt      = w_pld_sel[DATA_WIDTH-1:0];
                    w_sop_nxt       = 1'b0;
                    w_cnt_nxt       = w_cnt_inc;
                    if (w_pld_last) begin
                        w_eop_nxt   = 1'b1;
                        w_state_nxt = c_IDLE;
                    end else if (w_cnt_inc == c_CNT_W'(MAX_PLD_BEATS)) begin
                        // Truncate the TLP here; the rest of the payload is
                        // discarded so the next TLP starts cleanly.
                        w_eop_nxt   = 1'b1;
                        w_set_ovr   = 1'b1;
                        w_state_nxt = c_DRAIN;
                    end else begin
                        w_eop_nxt   = 1'b0;
                    end
                end
            end
            c_DRAIN: begin
                // Output register is not touched; beats are dropped silently.
                if (w_pld_avail) begin
                    w_pld_pop[r_ch] = 1'b1;
                    if (w_pld_last) begin
                        w_state_nxt = c_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_ptr     <= '0;
            r_ch      <= '0;
            r_cnt     <= '0;
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_sop     <= 1'b0;
            r_eop     <= 1'b0;
            r_overrun <= 1'b0;
            r_tlp_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_load_ok) begin
                r_valid <= w_load;
            end
            if (w_load) begin
                r_data <= w_data_nxt;
                r_sop  <= w_sop_nxt;
                r_eop  <= w_eop_nxt;
            end
            if (w_grant) begin
                r_ch  <= w_gnt;
                r_ptr <= w_ptr_next;
            end
            if (w_set_ovr) begin
                r_overrun <= 1'b1;
            end
            if (r_valid && tlp_ready_i && r_eop) begin
                r_tlp_cnt <= r_tlp_cnt + 32'd1;
            end
        end
    end

    // Pops are combinational; suppress them while reset is asserted so an
    // abandoned packet does not consume FIFO entries.
    assign hdr_rden_o    = rst ? '0 : w_hdr_pop;
    assign pld_rden_o    = rst ? '0 : w_pld_pop;
    assign tlp_valid_o   = r_valid;
    assign tlp_data_o    = r_data;
    assign tlp_sop_o     = r_sop;
    assign tlp_eop_o     = r_eop;
    assign tlp_ch_o      = r_ch;
    assign pld_overrun_o = r_overrun;
    assign tlp_cnt_o     = r_tlp_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pcie_tlp_assembler.sv
`default_nettype none
// ============================================================================
// Module      : tb_pcie_tlp_assembler
// Description : Self-checking bench for pcie_tlp_assembler (2 channels,
//               channel 0 carries payload, 4-beat payload limit). FIFOs are
//               modelled with queues; expected beats are built per TLP.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pcie_tlp_assembler;

    localparam int          c_NUM_CH  = 2;
    localparam int          c_HW      = 128;
    localparam int          c_DW      = 256;
    localparam logic [1:0]  c_HAS_PLD = 2'b01;
    localparam int          c_MAX     = 4;

    logic                        clk;
    logic                        rst;
    logic [c_NUM_CH-1:0]         hdr_empty_i;
    logic [c_NUM_CH*c_HW-1:0]    hdr_rdata_i;
    logic [c_NUM_CH-1:0]         hdr_rden_o;
    logic [c_NUM_CH-1:0]         pld_empty_i;
    logic [c_NUM_CH*(c_DW+1)-1:0] pld_rdata_i;
    logic [c_NUM_CH-1:0]         pld_rden_o;
    logic                        tlp_valid_o;
    logic                        tlp_ready_i;
    logic [c_DW-1:0]             tlp_data_o;
    logic                        tlp_sop_o;
    logic                        tlp_eop_o;
    logic [0:0]                  tlp_ch_o;
    logic                        pld_overrun_o;
    logic [31:0]                 tlp_cnt_o;

    pcie_tlp_assembler #(
        .NUM_CH        (c_NUM_CH),
        .HDR_WIDTH     (c_HW),
        .DATA_WIDTH    (c_DW),
        .HAS_PLD       (c_HAS_PLD),
        .MAX_PLD_BEATS (c_MAX)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .hdr_empty_i   (hdr_empty_i),
        .hdr_rdata_i   (hdr_rdata_i),
        .hdr_rden_o    (hdr_rden_o),
        .pld_empty_i   (pld_empty_i),
        .pld_rdata_i   (pld_rdata_i),
        .pld_rden_o    (pld_rden_o),
        .tlp_valid_o   (tlp_valid_o),
        .tlp_ready_i   (tlp_ready_i),
        .tlp_data_o    (tlp_data_o),
        .tlp_sop_o     (tlp_sop_o),
        .tlp_eop_o     (tlp_eop_o),
        .tlp_ch_o      (tlp_ch_o),
        .pld_overrun_o (pld_overrun_o),
        .tlp_cnt_o     (tlp_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed { logic last; logic [c_DW-1:0] d; } pbeat_t;
    typedef struct packed { logic [c_DW-1:0] d; logic sop; logic eop; logic ch; } beat_t;
    typedef struct {
        int          ch;
        int          npld;
        logic [15:0] rdy;
        int          exp_vcyc;
        int          exp_hpop;
        int          exp_ppop;
        logic        exp_ov;
    } vec_t;

    logic [c_HW-1:0] hq0[$];
    logic [c_HW-1:0] hq1[$];
    pbeat_t          pq0[$];
    beat_t           expq[$];

    int          checks;
    int          failures;
    int          model_cnt;
    logic        model_ov;
    int          hdr_pops;
    int          pld_pops;
    int          vcyc;
    int          cyc;
    logic        mon_en;
    logic        rst_req;
    logic        rand_ready;
    logic [15:0] rdy_pat;
    logic        stalled;
    beat_t       held;

    task automatic chk(input string name, input logic [c_DW-1:0] got, input logic [c_DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic logic [c_DW-1:0] rand_word();
        logic [c_DW-1:0] w;
        for (int k = 0; k < c_DW / 32; k++) w[k*32 +: 32] = $urandom;
        return w;
    endfunction

    // Queue one TLP on a channel and append its expected output beats.
    task automatic push_tlp(input int ch, input int npld);
        logic [c_HW-1:0] h;
        logic            has;
        beat_t           b;
        pbeat_t          p;
        h   = {$urandom, $urandom, $urandom, $urandom};
        has = c_HAS_PLD[ch];
        if (ch == 0) hq0.push_back(h);
        else         hq1.push_back(h);
        b.d   = {{(c_DW-c_HW){1'b0}}, h};
        b.sop = 1'b1;
        b.eop = !has;
        b.ch  = ch[0];
        expq.push_back(b);
        model_cnt++;
        if (has) begin
            for (int k = 1; k <= npld; k++) begin
                p.d    = rand_word();
                p.last = (k == npld);
                pq0.push_back(p);
                if (k <= c_MAX) begin
                    b.d   = p.d;
                    b.sop = 1'b0;
                    b.eop = (k == npld) || (k == c_MAX);
                    b.ch  = ch[0];
                    expq.push_back(b);
                end
            end
            if (npld > c_MAX) model_ov = 1'b1;
        end
    endtask

    task automatic drive();
        rst         = rst_req;
        hdr_empty_i = {hq1.size() == 0, hq0.size() == 0};
        hdr_rdata_i = '0;
        if (hq0.size() != 0) hdr_rdata_i[c_HW-1:0]      = hq0[0];
        if (hq1.size() != 0) hdr_rdata_i[2*c_HW-1:c_HW] = hq1[0];
        pld_empty_i = {1'b1, pq0.size() == 0};
        pld_rdata_i = '0;
        if (pq0.size() != 0) pld_rdata_i[c_DW:0] = pq0[0];
        if (rand_ready)    tlp_ready_i = ($urandom_range(0, 3) != 0);
        else if (cyc < 16) tlp_ready_i = rdy_pat[cyc];
        else               tlp_ready_i = 1'b1;
    endtask

    task automatic observe();
        beat_t e;
        beat_t cur;
        cur = '{d: tlp_data_o, sop: tlp_sop_o, eop: tlp_eop_o, ch: tlp_ch_o[0]};
        if (mon_en) begin
            if (hdr_rden_o[0]) begin
                chk("hdr0_pop_nonempty", 256'(hq0.size() != 0), 256'd1);
                if (hq0.size() != 0) void'(hq0.pop_front());
                hdr_pops++;
            end
            if (hdr_rden_o[1]) begin
                chk("hdr1_pop_nonempty", 256'(hq1.size() != 0), 256'd1);
                if (hq1.size() != 0) void'(hq1.pop_front());
                hdr_pops++;
            end
            if (pld_rden_o[0]) begin
                chk("pld0_pop_nonempty", 256'(pq0.size() != 0), 256'd1);
                if (pq0.size() != 0) void'(pq0.pop_front());
                pld_pops++;
            end
            if (pld_rden_o[1]) chk("pld1_pop", 256'd1, 256'd0);
            if (tlp_valid_o) vcyc++;
            if (stalled) begin
                chk("stall_valid", 256'(tlp_valid_o), 256'd1);
                chk("stall_data", tlp_data_o, held.d);
                chk("stall_flags", 256'({cur.sop, cur.eop, cur.ch}), 256'({held.sop, held.eop, held.ch}));
            end
            if (tlp_valid_o && tlp_ready_i) begin
                if (expq.size() == 0) begin
                    chk("beat_unexpected", 256'd1, 256'd0);
                end else begin
                    e = expq.pop_front();
                    chk("beat_data", tlp_data_o, e.d);
                    chk("beat_sop_eop_ch", 256'({cur.sop, cur.eop, cur.ch}), 256'({e.sop, e.eop, e.ch}));
                end
            end
            stalled = tlp_valid_o && !tlp_ready_i;
            held    = cur;
        end
        cyc++;
    endtask

    task automatic step();
        @(negedge clk);
        drive();
        #1;
        observe();
    endtask

    task automatic run_until_done(input int bound);
        logic done;
        done = 1'b0;
        for (int i = 0; i < bound && !done; i++) begin
            step();
            if (hq0.size() == 0 && hq1.size() == 0 && pq0.size() == 0 &&
                expq.size() == 0 && !tlp_valid_o) done = 1'b1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL run_timeout pending_beats=%0d required=0", expq.size());
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 256'(tlp_valid_o), 256'd0);
        chk({tag, "_data"}, tlp_data_o, 256'd0);
        chk({tag, "_sop_eop_ch"}, 256'({tlp_sop_o, tlp_eop_o, tlp_ch_o}), 256'd0);
        chk({tag, "_overrun"}, 256'(pld_overrun_o), 256'd0);
        chk({tag, "_cnt"}, 256'(tlp_cnt_o), 256'd0);
    endtask

    vec_t tbl[7];

    initial begin
        int n0;
        int n1;
        tbl[0] = '{ch: 1, npld: 0, rdy: 16'hFFFF, exp_vcyc: 1, exp_hpop: 1, exp_ppop: 0, exp_ov: 1'b0};
        tbl[1] = '{ch: 0, npld: 4, rdy: 16'hFFFF, exp_vcyc: 5, exp_hpop: 1, exp_ppop: 4, exp_ov: 1'b0};
        tbl[2] = '{ch: 0, npld: 3, rdy: 16'hFFB3, exp_vcyc: 7, exp_hpop: 1, exp_ppop: 3, exp_ov: 1'b0};
        tbl[3] = '{ch: 0, npld: 1, rdy: 16'hFFFF, exp_vcyc: 2, exp_hpop: 1, exp_ppop: 1, exp_ov: 1'b0};
        tbl[4] = '{ch: 0, npld: 6, rdy: 16'hFFFF, exp_vcyc: 5, exp_hpop: 1, exp_ppop: 6, exp_ov: 1'b1};
        tbl[5] = '{ch: 1, npld: 0, rdy: 16'hFFFF, exp_vcyc: 1, exp_hpop: 1, exp_ppop: 0, exp_ov: 1'b1};
        tbl[6] = '{ch: 0, npld: 5, rdy: 16'hFFFF, exp_vcyc: 5, exp_hpop: 1, exp_ppop: 5, exp_ov: 1'b1};

        checks = 0; failures = 0; model_cnt = 0; model_ov = 1'b0;
        hdr_pops = 0; pld_pops = 0; vcyc = 0; cyc = 0;
        stalled = 1'b0; held = '0; rand_ready = 1'b0; rdy_pat = 16'hFFFF;
        rst = 1'b1; rst_req = 1'b1; mon_en = 1'b0;
        hdr_empty_i = '1; hdr_rdata_i = '0; pld_empty_i = '1; pld_rdata_i = '0; tlp_ready_i = 1'b0;

        // Power-on reset
        step();
        step();
        chk_all_zero("reset");
        chk("reset_pops", 256'({hdr_rden_o, pld_rden_o}), 256'd0);
        rst_req = 1'b0;
        mon_en  = 1'b1;

        // Header-only TLP: one cycle of latency from first sight to valid
        cyc = 0;
        push_tlp(1, 0);
        step();
        chk("lat_valid_first", 256'(tlp_valid_o), 256'd0);
        chk("lat_hdr_pop", 256'(hdr_rden_o), 256'd2);
        step();
        chk("lat_valid_next", 256'(tlp_valid_o), 256'd1);
        run_until_done(50);
        chk("lat_cnt", 256'(tlp_cnt_o), 256'(model_cnt));

        // Directed single-TLP vectors
        for (int t = 0; t < 7; t++) begin
            hdr_pops = 0; pld_pops = 0; vcyc = 0; cyc = 0;
            rdy_pat  = tbl[t].rdy;
            push_tlp(tbl[t].ch, tbl[t].npld);
            run_until_done(100);
            chk($sformatf("vec%0d_valid_cycles", t), 256'(vcyc), 256'(tbl[t].exp_vcyc));
            chk($sformatf("vec%0d_hdr_pops", t), 256'(hdr_pops), 256'(tbl[t].exp_hpop));
            chk($sformatf("vec%0d_pld_pops", t), 256'(pld_pops), 256'(tbl[t].exp_ppop));
            chk($sformatf("vec%0d_overrun", t), 256'(pld_overrun_o), 256'(tbl[t].exp_ov));
            chk($sformatf("vec%0d_tlp_cnt", t), 256'(tlp_cnt_o), 256'(model_cnt));
        end

        // Reset in the middle of a payload
        cyc = 0; rdy_pat = 16'hFFFF;
        push_tlp(0, 6);
        step();
        step();
        step();
        mon_en  = 1'b0;
        rst_req = 1'b1;
        step();
        chk("midrst_hdr_pop", 256'(hdr_rden_o), 256'd0);
        chk("midrst_pld_pop", 256'(pld_rden_o), 256'd0);
        hq0.delete(); hq1.delete(); pq0.delete(); expq.delete();
        model_cnt = 0; model_ov = 1'b0; stalled = 1'b0;
        rst_req = 1'b0;
        step();
        chk_all_zero("midrst");
        mon_en = 1'b1;
        // Pointer must be back at channel 0: ch0 wins although ch0 was last granted
        cyc = 0;
        push_tlp(0, 2);
        push_tlp(1, 0);
        run_until_done(100);
        chk("midrst_after_cnt", 256'(tlp_cnt_o), 256'(model_cnt));

        // Randomised traffic, both channels kept eligible: strict alternation
        rand_ready = 1'b1;
        hdr_pops = 0;
        n0 = $urandom_range(8, 15);
        n1 = $urandom_range(8, 15);
        for (int i = 0; i < 15; i++) begin
            if (i < n0) push_tlp(0, $urandom_range(1, 6));
            if (i < n1) push_tlp(1, 0);
        end
        run_until_done(3000);
        chk("rand_tlp_cnt", 256'(tlp_cnt_o), 256'(model_cnt));
        chk("rand_overrun", 256'(pld_overrun_o), 256'(model_ov));
        chk("rand_hdr_pops", 256'(hdr_pops), 256'(n0 + n1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
